// File: rtl/countdown_counter.sv
// countdown_counter
// -----------------------------------------------------------------------------
// Loadable down-counter with prescaler, enable and terminal-count flag. A preset
// is loaded into both the count and a reload register; after Start the count
// decrements once every PRESCALE enabled clock cycles until it reaches zero,
// where Done is raised. The count drives board lights directly.
//
// Parameters:
//   WIDTH     counter width in bits (>= 1)
//   PRESCALE  clock cycles per decrement (>= 1, 1 = every cycle)
//
// Ports:
//   Clock      in   rising-edge clock
//   Reset      in   asynchronous active-high reset, clears all state
//   Load       in   load LoadValue into count and reload register (highest prio)
//   LoadValue  in   preset value, WIDTH bits
//   Start      in   start from IDLE or restart from DONE
//   Enable     in   freezes count and prescaler while low in RUN
//   Count      out  current count, WIDTH bits (registered)
//   Busy       out  high while in RUN (registered)
//   Done       out  terminal-count flag (registered)
//
// Optional feature macro: COUNTDOWN_AUTO_RELOAD_EN
//   When defined, the terminal tick in RUN reloads the count from the reload
//   register, stays in RUN and pulses Done for one cycle.
// -----------------------------------------------------------------------------
module countdown_counter #(
  parameter int WIDTH    = 3,
  parameter int PRESCALE = 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadValue,
  input  logic             Start,
  input  logic             Enable,
  output logic [WIDTH-1:0] Count,
  output logic             Busy,
  output logic             Done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_r, state_s;
  logic [WIDTH-1:0] count_r, count_s;
  logic [WIDTH-1:0] reload_r, reload_s;
  logic [PW-1:0]    pre_r, pre_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic             tick_s;

  // Next-state logic: Load beats Start beats the prescaled tick.
  always_comb begin
    state_s  = state_r;
    count_s  = count_r;
    reload_s = reload_r;
    pre_s    = pre_r;
    done_s   = done_r;
    tick_s   = Enable && (pre_r == PRE_LAST);

    if (Load) begin
      count_s  = LoadValue;
      reload_s = LoadValue;
      pre_s    = {PW{1'b0}};
      done_s   = 1'b0;
      state_s  = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (Start) begin
            if (count_r == {WIDTH{1'b0}}) begin
              state_s = DONE;
              done_s  = 1'b1;
            end else begin
              state_s = RUN;
              pre_s   = {PW{1'b0}};
            end
          end else begin
            state_s = IDLE;
          end
        end
        RUN: begin
          // Done is only ever a one-cycle pulse while running.
          done_s = 1'b0;
          if (tick_s) begin
            pre_s = {PW{1'b0}};
            if (count_r == WIDTH'(1)) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
              count_s = reload_r;
              done_s  = 1'b1;
`else
              count_s = {WIDTH{1'b0}};
              done_s  = 1'b1;
              state_s = DONE;
`endif
            end else begin
              // count_r is never 0 here, so this cannot wrap
              count_s = count_r - WIDTH'(1);
            end
          end else if (Enable) begin
            pre_s = pre_r + PW'(1);
          end else begin
            pre_s = pre_r;
          end
        end
        DONE: begin
          if (Start) begin
            count_s = reload_r;
            if (reload_r != {WIDTH{1'b0}}) begin
              state_s = RUN;
              pre_s   = {PW{1'b0}};
              done_s  = 1'b0;
            end else begin
              done_s  = 1'b1;
            end
          end else begin
            count_s = {WIDTH{1'b0}};
            done_s  = 1'b1;
          end
        end
        default: begin
          state_s = IDLE;
          count_s = {WIDTH{1'b0}};
          pre_s   = {PW{1'b0}};
          done_s  = 1'b0;
        end
      endcase
    end

    busy_s = (state_s == RUN);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r  <= IDLE;
      count_r  <= {WIDTH{1'b0}};
      reload_r <= {WIDTH{1'b0}};
      pre_r    <= {PW{1'b0}};
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      count_r  <= count_s;
      reload_r <= reload_s;
      pre_r    <= pre_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
    end
  end

  assign Count = count_r;
  assign Busy  = busy_r;
  assign Done  = done_r;

endmodule

// File: tb/tb_countdown_counter.sv
// Self-checking bench for countdown_counter (WIDTH=3, PRESCALE=2): reset state,
// a directed vector table, hand-written multi-cycle sequences and randomized
// stimulus against a reference model that expresses the count in terms of the
// number of enabled cycles elapsed since Start.
module tb_countdown_counter;

  localparam int W = 3;
  localparam int P = 2;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic         Clock = 1'b0;
  logic         Reset;
  logic         Load;
  logic [W-1:0] LoadValue;
  logic         Start;
  logic         Enable;
  logic [W-1:0] Count;
  logic         Busy;
  logic         Done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clock = ~Clock;

  countdown_counter #(.WIDTH(W), .PRESCALE(P)) dut (
    .Clock(Clock), .Reset(Reset), .Load(Load), .LoadValue(LoadValue),
    .Start(Start), .Enable(Enable), .Count(Count), .Busy(Busy), .Done(Done)
  );

  typedef struct {
    logic         load;
    logic [W-1:0] lv;
    logic         start;
    logic         en;
    logic [W-1:0] c;
    logic         b;
    logic         d;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string name, input int c, input int b, input int d);
    check({name, ".Count"}, 32'(Count), 32'(c));
    check({name, ".Busy"},  32'(Busy),  32'(b));
    check({name, ".Done"},  32'(Done),  32'(d));
  endtask

  // Drive inputs just after an edge, then advance one edge and settle.
  task automatic step(input logic ld, input logic [W-1:0] lv, input logic st, input logic en);
    Load = ld; LoadValue = lv; Start = st; Enable = en;
    @(posedge Clock);
    #1;
  endtask

  // Reference model: mode 0 idle, 1 run, 2 done; m_e = enabled cycles since Start.
  int m_mode, m_reload, m_e;
  bit m_pulse;

  function automatic void model_reset();
    m_mode = 0; m_reload = 0; m_e = 0; m_pulse = 1'b0;
  endfunction

  function automatic void model_step(input bit ld, input int lv, input bit st, input bit en);
    m_pulse = 1'b0;
    if (ld) begin
      m_mode = 0; m_reload = lv; m_e = 0;
    end else if (m_mode == 0) begin
      if (st) begin
        m_mode = (m_reload == 0) ? 2 : 1;
        m_e = 0;
      end
    end else if (m_mode == 1) begin
      if (en) begin
        m_e++;
        if (m_e % P == 0) begin
          if (!AUTO && (m_e / P) == m_reload) m_mode = 2;
          else if (AUTO && ((m_e / P) % m_reload) == 0) m_pulse = 1'b1;
        end
      end
    end else begin
      if (st && m_reload != 0) begin
        m_mode = 1; m_e = 0;
      end
    end
  endfunction

  function automatic int model_count();
    if (m_mode == 0) return m_reload;
    if (m_mode == 1) return m_reload - ((m_e / P) % m_reload);
    return 0;
  endfunction

  initial begin
    int done_edge;
    Reset = 1'b1; Load = 1'b0; LoadValue = '0; Start = 1'b0; Enable = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    check_out("reset", 0, 0, 0);
    Reset = 1'b0;

    // load, start,  en,  count, busy, done
    vecs[0]  = '{1'b1, 3'd5, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 3'd0, 1'b1, 1'b1, 3'd5, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 3'd0, 1'b0, 1'b1, 3'd5, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 3'd0, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 3'd0, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 3'd0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 3'd0, 1'b0, 1'b1, 3'd3, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 3'd0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 3'd0, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 3'd0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 3'd0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 3'd0, 1'b1, 1'b1, 3'd5, 1'b1, 1'b0};
    vecs[14] = '{1'b0, 3'd0, 1'b0, 1'b1, 3'd5, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 3'd0, 1'b0, 1'b1, 3'd4, 1'b1, 1'b0};
    vecs[16] = '{1'b1, 3'd2, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 3'd0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 3'd0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1};
    vecs[20] = '{1'b0, 3'd0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1};
    vecs[21] = '{1'b0, 3'd0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1};

`ifndef COUNTDOWN_AUTO_RELOAD_EN
    for (int i = 0; i < 22; i++) begin
      step(vecs[i].load, vecs[i].lv, vecs[i].start, vecs[i].en);
      check_out($sformatf("vec%0d", i), int'(vecs[i].c), int'(vecs[i].b), int'(vecs[i].d));
    end

    // Load 7: full descent without wrapping, then sticky zero.
    step(1'b1, 3'd7, 1'b0, 1'b1);
    step(1'b0, 3'd0, 1'b1, 1'b1);
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 3'd0, 1'b0, 1'b1);
      check_out($sformatf("load7_e%0d", i), (i >= 14) ? 0 : 7 - i / 2,
                (i >= 14) ? 0 : 1, (i >= 14) ? 1 : 0);
    end

    // Pause for 7 cycles after the first decrement; completion slips by 7.
    step(1'b1, 3'd4, 1'b0, 1'b1);
    step(1'b0, 3'd0, 1'b1, 1'b1);
    step(1'b0, 3'd0, 1'b0, 1'b1);
    step(1'b0, 3'd0, 1'b0, 1'b1);
    check("pause_first_dec", 32'(Count), 32'd3);
    for (int i = 3; i <= 9; i++) begin
      step(1'b0, 3'd0, 1'b0, 1'b0);
      check($sformatf("pause_hold_e%0d", i), 32'(Count), 32'd3);
    end
    done_edge = -1;
    for (int i = 10; i <= 30; i++) begin
      step(1'b0, 3'd0, 1'b0, 1'b1);
      if (Done && done_edge < 0) done_edge = i;
    end
    check("pause_done_edge", 32'(done_edge), 32'd15);

    // Asynchronous reset between edges during a run.
    step(1'b1, 3'd5, 1'b0, 1'b1);
    step(1'b0, 3'd0, 1'b1, 1'b1);
    step(1'b0, 3'd0, 1'b0, 1'b1);
    step(1'b0, 3'd0, 1'b0, 1'b1);
    #2;
    Reset = 1'b1;
    #1;
    check_out("async_reset", 0, 0, 0);
    Reset = 1'b0;
`else
    // Auto-reload: load 3, count 3,3,2,2,1,1,3,... with a Done pulse on reload.
    step(1'b1, 3'd3, 1'b0, 1'b1);
    step(1'b0, 3'd0, 1'b1, 1'b1);
    check_out("auto_e0", 3, 1, 0);
    for (int i = 1; i <= 14; i++) begin
      step(1'b0, 3'd0, 1'b0, 1'b1);
      check_out($sformatf("auto_e%0d", i), 3 - ((i / 2) % 3), 1,
                (i % 2 == 0 && (i / 2) % 3 == 0) ? 1 : 0);
    end
    Reset = 1'b1;
    #1;
    check_out("async_reset", 0, 0, 0);
    Reset = 1'b0;
`endif

    // Randomized stimulus against the reference model.
    @(posedge Clock);
    #1;
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      bit ld, st, en;
      logic [W-1:0] lv;
      ld = ($urandom_range(0, 15) == 0);
      lv = W'($urandom);
      st = ($urandom_range(0, 7) == 0);
      en = ($urandom_range(0, 3) != 0);
      model_step(ld, int'(lv), st, en);
      step(ld, lv, st, en);
      check_out($sformatf("rand%0d", i), model_count(), (m_mode == 1) ? 1 : 0,
                (m_mode == 2 || m_pulse) ? 1 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
